// File: rtl/sub_8bit_serial.sv
// rtl/sub_8bit_serial.sv - byte-serial multi-precision subtractor D = M - N
//
// Purpose: subtracts unsigned operands of up to MAX_BYTES bytes. The operands
// arrive least-significant byte first, one minuend/subtrahend byte pair per
// beat. The borrow is carried between beats internally. A single registered
// output stage sits behind a valid/ready handshake.
//
// Optional feature: define SUB_SERIAL_ZERO_FLAG_EN to add the zero_o port.
// zero_o reports that the whole result was zero.
//
// Parameters:
//   MAX_BYTES  maximum operand length in bytes (1..255); an operand that
//              reaches this length is ended and flagged with len_err_o
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   valid_i    input byte pair valid
//   ready_o    block can accept input this cycle
//   M_i        minuend byte
//   N_i        subtrahend byte
//   last_i     most-significant byte of the current operand
//   valid_o    difference byte valid
//   ready_i    downstream accepts output
//   diff_o     difference byte
//   last_o     final byte of the current result
//   borrow_o   final borrow, qualified by last_o (1 means M < N)
//   len_err_o  operand truncated at MAX_BYTES, qualified by valid_o
//   zero_o     whole result is zero, qualified by last_o (optional)

module sub_8bit_serial #(
  parameter int MAX_BYTES = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [7:0] M_i,
  input  logic [7:0] N_i,
  input  logic       last_i,
  output logic       valid_o,
  input  logic       ready_i,
  output logic [7:0] diff_o,
  output logic       last_o,
  output logic       borrow_o,
  output logic       len_err_o
`ifdef SUB_SERIAL_ZERO_FLAG_EN
  ,
  output logic       zero_o
`endif
);

  localparam int CW = $clog2(MAX_BYTES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic            borrow_q;
  logic [CW-1:0]   count;

  logic            accept;
  logic            b_in;
  logic [8:0]      sub;
  logic [CW-1:0]   count_next;
  logic            trunc;
  logic            fin;

  // The output register is the only stage. It can take a new beat whenever
  // it is empty or is being drained in this same cycle.
  assign ready_o = !valid_o || ready_i;
  assign accept  = valid_i && ready_o;

  always_comb begin
    b_in       = (state == BUSY) ? borrow_q : 1'b0;
    sub        = {1'b0, M_i} - {1'b0, N_i} - {8'd0, b_in};
    // count is held at 0 in IDLE, so this value is the 1-based index of the
    // current beat within the operand.
    count_next = count + CW'(1);
    trunc      = (count_next == CW'(MAX_BYTES));
    fin        = last_i || trunc;
  end

`ifdef SUB_SERIAL_ZERO_FLAG_EN
  logic zacc;
  logic zero_now;

  // The first beat of an operand starts from a fresh "all zero so far".
  always_comb begin
    zero_now = (sub[7:0] == 8'd0) && ((state == IDLE) ? 1'b1 : zacc);
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      borrow_q  <= 1'b0;
      count     <= '0;
      valid_o   <= 1'b0;
      diff_o    <= 8'd0;
      last_o    <= 1'b0;
      borrow_o  <= 1'b0;
      len_err_o <= 1'b0;
`ifdef SUB_SERIAL_ZERO_FLAG_EN
      zacc      <= 1'b1;
      zero_o    <= 1'b0;
`endif
    end else if (accept) begin
      valid_o   <= 1'b1;
      diff_o    <= sub[7:0];
      last_o    <= fin;
      borrow_o  <= fin ? sub[8] : 1'b0;
      len_err_o <= trunc;
`ifdef SUB_SERIAL_ZERO_FLAG_EN
      zero_o    <= fin && zero_now;
`endif
      if (fin) begin
        // Operand complete, either by last_i or by hitting MAX_BYTES. The
        // next beat starts a new operand with no borrow.
        state    <= IDLE;
        borrow_q <= 1'b0;
        count    <= '0;
`ifdef SUB_SERIAL_ZERO_FLAG_EN
        zacc     <= 1'b1;
`endif
      end else begin
        state    <= BUSY;
        borrow_q <= sub[8];
        count    <= count_next;
`ifdef SUB_SERIAL_ZERO_FLAG_EN
        zacc     <= zero_now;
`endif
      end
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule
